cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the result ports of the functional units (branch, ALU, LSU, ...).

---
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus between functional-unit result
// ports. One winner per cycle is registered onto cdb/cdb_valid. Requester 0 may
// take strict priority (PRIO0=1); a per-requester wait counter forces a starved
// requester through ahead of that priority.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   clear      synchronous flush (branch miss), suppresses grants this cycle
//   req_data   requester i word at [i*CDB_DW +: CDB_DW]
//   req_valid  requester i has a result
//   req_ready  one-hot grant (combinational), only where req_valid=1
//   cdb        registered broadcast word
//   cdb_valid  cdb carries a new result this cycle
//   grant_id   index of the requester that drove cdb

// Per-requester starvation counter. Counts cycles a valid requester loses,
// saturating at MAX_WAIT; any grant, idle cycle or flush clears it.
module cdb_wait_cnt #(
  parameter  int MAX_WAIT = 8,
  localparam int WW       = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  input  logic granted,
  output logic starved
);
  logic [WW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)                 cnt <= '0;
    else if (!valid || granted)       cnt <= '0;
    else if (cnt != WW'(MAX_WAIT))    cnt <= cnt + WW'(1);
  end

  // A stale count on a requester that just dropped valid must not win.
  assign starved = valid && (cnt == WW'(MAX_WAIT));
endmodule

module cdb_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int CDB_DW   = 32,
  parameter  int PRIO0    = 1,
  parameter  int MAX_WAIT = 8,
  localparam int IW       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [N_REQ*CDB_DW-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [CDB_DW-1:0]       cdb,
  output logic                    cdb_valid,
  output logic [IW-1:0]           grant_id
);
  logic [N_REQ-1:0][CDB_DW-1:0] req_words;
  logic [N_REQ-1:0]             starved;
  logic [N_REQ-1:0]             rr_mask;
  logic [IW-1:0]                rr_ptr;
  logic [IW-1:0]                win;
  logic                         gnt;
  logic                         rr_upd;

  assign req_words = req_data;

  // First set bit of m searching p+1, p+2, ... modulo N_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] m,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && m[idx[IW-1:0]]) begin
        r     = idx[IW-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_wc
      cdb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wc (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .valid   (req_valid[gi]),
        .granted (req_ready[gi]),
        .starved (starved[gi])
      );
    end
  endgenerate

  // Grant selection: flush, then starved, then requester-0 priority, then RR.
  always_comb begin
    rr_mask = req_valid;
    if (PRIO0 != 0) rr_mask[0] = 1'b0;
    gnt    = 1'b0;
    win    = '0;
    rr_upd = 1'b0;
    if (rst || clear) begin
      gnt = 1'b0;
    end else if (|starved) begin
      gnt    = 1'b1;
      win    = rr_pick(starved, rr_ptr);
      rr_upd = 1'b1;
    end else if ((PRIO0 != 0) && req_valid[0]) begin
      gnt = 1'b1;
      win = '0;
    end else if (|rr_mask) begin
      gnt    = 1'b1;
      win    = rr_pick(rr_mask, rr_ptr);
      rr_upd = 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) req_ready[i] = gnt && (win == IW'(i));
  end

  // No backpressure on the CDB: the register reloads every cycle, and on an
  // idle cycle only the valid drops so cdb/grant_id keep the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb       <= '0;
      cdb_valid <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
    end else begin
      cdb_valid <= gnt;
      if (gnt) begin
        cdb      <= req_words[win];
        grant_id <= win;
      end
      if (rr_upd) rr_ptr <= win;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst, clear;
  logic [N-1:0][DW-1:0] words;
  logic [N*DW-1:0]      req_data;
  logic [N-1:0]         req_valid;

  logic [N-1:0]  rdy_rr, rdy_pr;
  logic [DW-1:0] cdb_rr, cdb_pr;
  logic          cv_rr, cv_pr;
  logic [1:0]    gid_rr, gid_pr;

  int n_cmp = 0;
  int n_bad = 0;

  assign req_data = words;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .CDB_DW(DW), .PRIO0(0), .MAX_WAIT(8)) u_rr (
    .clk(clk), .rst(rst), .clear(clear), .req_data(req_data), .req_valid(req_valid),
    .req_ready(rdy_rr), .cdb(cdb_rr), .cdb_valid(cv_rr), .grant_id(gid_rr));

  cdb_arbiter #(.N_REQ(N), .CDB_DW(DW), .PRIO0(1), .MAX_WAIT(4)) u_pr (
    .clk(clk), .rst(rst), .clear(clear), .req_data(req_data), .req_valid(req_valid),
    .req_ready(rdy_pr), .cdb(cdb_pr), .cdb_valid(cv_pr), .grant_id(gid_pr));

  task automatic chk(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e3[10];
    int e5[5];
    e3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    e5 = '{0, 0, 0, 0, 1};
    for (int i = 0; i < N; i++) words[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; clear = 1'b0; req_valid = 4'b1111;

    tick;
    chk("rst_rdy_rr", rdy_rr === 4'b0000);
    chk("rst_rdy_pr", rdy_pr === 4'b0000);
    tick;
    chk("rst_cv_rr", cv_rr === 1'b0);
    chk("rst_cdb_rr", cdb_rr === 32'h0);
    chk("rst_gid_rr", gid_rr === 2'd0);
    chk("rst_cv_pr", cv_pr === 1'b0);

    rst = 1'b0; req_valid = 4'b0100; words[2] = 32'hCAFE_0002;
    #1;
    chk("t1_rdy_rr", rdy_rr === 4'b0100);
    chk("t1_rdy_pr", rdy_pr === 4'b0100);
    tick;
    chk("t1_cv", cv_rr === 1'b1);
    chk("t1_cdb", cdb_rr === 32'hCAFE_0002);
    chk("t1_gid", gid_rr === 2'd2);
    chk("t1_gid_pr", gid_pr === 2'd2);
    req_valid = 4'b0000;
    #1;
    chk("t1_rdy_idle", rdy_rr === 4'b0000);
    tick;
    chk("t1_cv_drop", cv_rr === 1'b0);
    chk("t1_cdb_hold", cdb_rr === 32'hCAFE_0002);

    req_valid = 4'b1000;
    tick;
    chk("t4_lone3", gid_rr === 2'd3);
    req_valid = 4'b1001;
    #1;
    chk("t4_rdy", rdy_rr === 4'b0001);
    tick;
    chk("t4_g0", gid_rr === 2'd0);
    tick;
    chk("t4_g3", gid_rr === 2'd3);
    chk("t4_cv", cv_rr === 1'b1);

    rst = 1'b1; req_valid = 4'b0000;
    tick;
    rst = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t2_gid", gid_rr === 2'(k % 4));
      chk("t2_cv", cv_rr === 1'b1);
      chk("t2_cdb", cdb_rr === words[k % 4]);
    end

    rst = 1'b1; req_valid = 4'b0000;
    tick;
    rst = 1'b0; req_valid = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("t3_gid", gid_pr === 2'(e3[k]));
      chk("t3_cv", cv_pr === 1'b1);
    end

    rst = 1'b1; req_valid = 4'b0000;
    tick;
    rst = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t5_gid_rr", gid_rr === 2'(k % 4));
      chk("t5_gid_pr", gid_pr === 2'(e5[k]));
    end
    clear = 1'b1;
    #1;
    chk("t5_rdy_rr", rdy_rr === 4'b0000);
    chk("t5_rdy_pr", rdy_pr === 4'b0000);
    chk("t5_cv_inflight", cv_rr === 1'b1);
    tick;
    chk("t5_cv_rr", cv_rr === 1'b0);
    chk("t5_cv_pr", cv_pr === 1'b0);
    chk("t5_gid_hold", gid_rr === 2'd0);
    clear = 1'b0;
    #1;
    chk("t5_resume_rr", rdy_rr === 4'b0010);
    chk("t5_cnt_cleared", rdy_pr === 4'b0001);
    tick;
    chk("t5_gid_resume", gid_rr === 2'd1);
    chk("t5_cv_resume", cv_rr === 1'b1);

    req_valid = 4'b0000;
    tick;
    chk("t6_cv_idle", cv_rr === 1'b0);
    chk("t6_cdb_hold", cdb_rr === words[1]);
    req_valid = 4'b1111;
    tick;
    chk("t6_burst", cv_rr === 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rdy_rst", rdy_rr === 4'b0000);
    tick;
    chk("t6_cv_rst", cv_rr === 1'b0);
    chk("t6_gid_rst", gid_rr === 2'd0);
    chk("t6_cdb_rst", cdb_rr === 32'h0);
    chk("t6_gid_rst_pr", gid_pr === 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
